// File: rtl/ysyx_23060208_mem_rd_arbiter.sv
// Two-requester (IFU/LSU) read arbiter onto a single AXI-lite-style memory read port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed LSU priority.
module ysyx_23060208_mem_rd_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    input  logic [DATA_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic [DATA_WIDTH-1:0] mem_araddr,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    input  logic [1:0]            mem_rresp,
    output logic                  mem_rready,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e                state_q;
    logic [1:0]            grant_q;
    logic [DATA_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  pick_lsu;
    logic                  in_idle;
    logic                  in_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu_q;  // last_grant: 0 = IFU, 1 = LSU

    // A tie goes to whoever was not served last.
    assign pick_lsu = lsu_arvalid && (!ifu_arvalid || !last_lsu_q);
`else
    assign pick_lsu = lsu_arvalid;
`endif

    assign in_idle = (state_q == S_IDLE) && !rst;
    assign in_data = (state_q == S_DATA);

    assign lsu_arready = in_idle && pick_lsu;
    assign ifu_arready = in_idle && ifu_arvalid && !pick_lsu;

    // Data phase is steered straight from the slave to the owner.
    assign ifu_rvalid = in_data && grant_q[0] && mem_rvalid;
    assign lsu_rvalid = in_data && grant_q[1] && mem_rvalid;
    assign mem_rready = in_data && ((grant_q[0] && ifu_rready) || (grant_q[1] && lsu_rready));
    assign rdata      = in_data ? mem_rdata : '0;
    assign rresp      = in_data ? mem_rresp : 2'b00;

    assign mem_araddr  = araddr_q;
    assign mem_arvalid = arvalid_q;
    assign grant       = grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        araddr_q  <= pick_lsu ? lsu_araddr : ifu_araddr;
                        arvalid_q <= 1'b1;
                        grant_q   <= pick_lsu ? 2'b10 : 2'b01;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (mem_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_rvalid && mem_rready) begin
                        grant_q    <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                        last_lsu_q <= grant_q[1];
`endif
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    grant_q   <= 2'b00;
                    arvalid_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_mem_rd_arbiter.sv
// Randomized transaction-level bench for ysyx_23060208_mem_rd_arbiter.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_ysyx_23060208_mem_rd_arbiter;

    logic        clk, rst;
    logic [31:0] ifu_araddr, lsu_araddr, rdata, mem_araddr, mem_rdata;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [1:0]  rresp, mem_rresp, grant;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

    int passed = 0;
    int total  = 0;

    // Requester-side model state.
    logic        pend_i, pend_l;
    logic [31:0] addr_i, addr_l;
    logic        last_lsu;

    ysyx_23060208_mem_rd_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .rdata(rdata), .rresp(rresp),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: LSU beats IFU, except round-robin alternates on ties.
    function automatic logic model_pick_lsu(input logic i, input logic l);
`ifdef ARB_ROUND_ROBIN_EN
        if (i && l) return !last_lsu;
`endif
        return l;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ifu_arready"}, ifu_arready, 1'b0);
        chk1({tag, "_lsu_arready"}, lsu_arready, 1'b0);
        chk1({tag, "_ifu_rvalid"}, ifu_rvalid, 1'b0);
        chk1({tag, "_lsu_rvalid"}, lsu_rvalid, 1'b0);
        chk1({tag, "_mem_arvalid"}, mem_arvalid, 1'b0);
        chk1({tag, "_mem_rready"}, mem_rready, 1'b0);
        chk32({tag, "_mem_araddr"}, mem_araddr, 32'h0);
        chk32({tag, "_rdata"}, rdata, 32'h0);
        chk32({tag, "_rresp"}, 32'(rresp), 32'h0);
        chk32({tag, "_grant"}, 32'(grant), 32'h0);
    endtask

    // One full transaction starting at a negedge in IDLE with pend_* describing requests.
    task automatic do_txn(input int ar_wait, input int r_wait, input int rr_wait,
                          input logic [31:0] rd, input logic [1:0] rsp);
        logic        wl;
        logic [31:0] waddr;
        logic [1:0]  wgrant;
        ifu_arvalid = pend_i; ifu_araddr = addr_i;
        lsu_arvalid = pend_l; lsu_araddr = addr_l;
        wl     = model_pick_lsu(pend_i, pend_l);
        waddr  = wl ? addr_l : addr_i;
        wgrant = wl ? 2'b10 : 2'b01;
        #1;
        chk1("idle_ifu_arready", ifu_arready, !wl);
        chk1("idle_lsu_arready", lsu_arready, wl);
        chk32("idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        if (wl) begin pend_l = 1'b0; lsu_arvalid = 1'b0; end
        else    begin pend_i = 1'b0; ifu_arvalid = 1'b0; end
        for (int k = 0; k < ar_wait; k++) begin
            #1;
            chk1("addr_hold_arvalid", mem_arvalid, 1'b1);
            chk32("addr_hold_araddr", mem_araddr, waddr);
            chk1("addr_no_ifu_arready", ifu_arready, 1'b0);
            chk1("addr_no_lsu_arready", lsu_arready, 1'b0);
            @(negedge clk);
        end
        mem_arready = 1'b1;
        #1;
        chk1("addr_arvalid", mem_arvalid, 1'b1);
        chk32("addr_araddr", mem_araddr, waddr);
        chk32("addr_grant", 32'(grant), 32'(wgrant));
        @(negedge clk);
        mem_arready = 1'b0;
        if (wl) lsu_rready = 1'b1; else ifu_rready = 1'b1;
        for (int k = 0; k < r_wait; k++) begin
            #1;
            chk1("data_arvalid_low", mem_arvalid, 1'b0);
            chk1("data_wait_rvalid", wl ? lsu_rvalid : ifu_rvalid, 1'b0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rd; mem_rresp = rsp;
        if (wl) lsu_rready = 1'b0; else ifu_rready = 1'b0;
        for (int k = 0; k < rr_wait; k++) begin
            #1;
            chk1("data_stall_rvalid", wl ? lsu_rvalid : ifu_rvalid, 1'b1);
            chk1("data_stall_mem_rready", mem_rready, 1'b0);
            @(negedge clk);
        end
        if (wl) lsu_rready = 1'b1; else ifu_rready = 1'b1;
        #1;
        chk1("data_ifu_rvalid", ifu_rvalid, !wl);
        chk1("data_lsu_rvalid", lsu_rvalid, wl);
        chk1("data_mem_rready", mem_rready, 1'b1);
        chk32("data_rdata", rdata, rd);
        chk32("data_rresp", 32'(rresp), 32'(rsp));
        chk32("data_grant", 32'(grant), 32'(wgrant));
        @(negedge clk);
        mem_rvalid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        last_lsu = wl;
        #1;
        chk32("done_grant", 32'(grant), 32'h0);
        chk1("done_ifu_rvalid", ifu_rvalid, 1'b0);
        chk1("done_lsu_rvalid", lsu_rvalid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1234; ifu_rready = 1'b0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h5678; lsu_rready = 1'b0;
        mem_arready = 1'b0; mem_rdata = 32'h0; mem_rvalid = 1'b0; mem_rresp = 2'b00;
        pend_i = 1'b0; pend_l = 1'b0; addr_i = 32'h0; addr_l = 32'h0; last_lsu = 1'b0;

        // Reset held mid-cycle with requests present: everything stays low.
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("post_reset");
        @(negedge clk);
        #1;
        chk32("no_req_grant", 32'(grant), 32'h0);
        chk1("no_req_mem_arvalid", mem_arvalid, 1'b0);

        // IFU alone, zero-wait slave.
        pend_i = 1'b1; addr_i = 32'h8000_0000;
        do_txn(0, 0, 0, 32'h0000_0413, 2'b00);

        // Contention sequence: tie, leftover/re-request, tie again.
        pend_i = 1'b1; addr_i = 32'h8000_0004;
        pend_l = 1'b1; addr_l = 32'h8000_1000;
        do_txn(0, 0, 0, 32'hAAAA_0001, 2'b00);
        do_txn(0, 0, 0, 32'hAAAA_0002, 2'b00);
        pend_i = 1'b1; pend_l = 1'b1;
        do_txn(0, 0, 0, 32'hAAAA_0003, 2'b00);
        if (pend_i || pend_l) do_txn(0, 0, 0, 32'hAAAA_0004, 2'b00);
        if (pend_i || pend_l) do_txn(0, 0, 0, 32'hAAAA_0005, 2'b00);

        // Slave stalls address phase for 5 cycles.
        pend_i = 1'b1; addr_i = 32'h8000_0100;
        do_txn(5, 1, 0, 32'hBEEF_0000, 2'b00);

        // Error response to the LSU is forwarded untouched.
        pend_l = 1'b1; addr_l = 32'h8000_2000;
        do_txn(0, 0, 0, 32'hDEAD_0000, 2'b10);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && ($urandom % 2 == 1)) begin pend_i = 1'b1; addr_i = $urandom & 32'hFFFF_FFFC; end
            if (!pend_l && ($urandom % 2 == 1)) begin pend_l = 1'b1; addr_l = $urandom & 32'hFFFF_FFFC; end
            if (!pend_i && !pend_l) begin pend_i = 1'b1; addr_i = $urandom & 32'hFFFF_FFFC; end
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   $urandom, 2'($urandom_range(0, 3)));
        end
        while (pend_i || pend_l) do_txn(0, 0, 0, $urandom, 2'b00);

        // Reset during the data phase with the slave beat on the wires.
        pend_i = 1'b1; addr_i = 32'h8000_0200;
        ifu_arvalid = 1'b1; ifu_araddr = addr_i;
        @(negedge clk);
        ifu_arvalid = 1'b0; pend_i = 1'b0; mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; ifu_rready = 1'b1;
        #1;
        chk1("pre_rst_ifu_rvalid", ifu_rvalid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_data");
        @(negedge clk);
        mem_rvalid = 1'b0; ifu_rready = 1'b0; rst = 1'b0;
        last_lsu = 1'b0;
        #1;
        chk32("after_rst_grant", 32'(grant), 32'h0);

        // First tie after reset follows the reset arbitration state.
        pend_i = 1'b1; addr_i = 32'h8000_0300;
        pend_l = 1'b1; addr_l = 32'h8000_3000;
        do_txn(0, 0, 0, 32'h1111_2222, 2'b00);
        do_txn(1, 0, 0, 32'h3333_4444, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
